// File: rtl/picosoc_iomem_initiator.sv
// Buffered PicoSoC iomem bus initiator: queues register requests, runs them one
// at a time with a timeout, and returns exactly one response per request.
module picosoc_iomem_initiator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  input  logic [3:0]                    req_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_error,
  output logic                          iomem_valid,
  output logic [3:0]                    iomem_wstrb,
  output logic [31:0]                   iomem_addr,
  output logic [31:0]                   iomem_wdata,
  input  logic                          iomem_ready,
  input  logic [31:0]                   iomem_rdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  req_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          iomem_valid_q, iomem_valid_d;
  logic [3:0]    iomem_wstrb_q, iomem_wstrb_d;
  logic [31:0]   iomem_addr_q, iomem_addr_d;
  logic [31:0]   iomem_wdata_q, iomem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_error_q, rsp_error_d;
  logic [7:0]    err_count_q, err_count_d;

  logic full, push, pop, tmo_hit;
  req_t head;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push    = req_valid && !full;
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign head    = mem_q[rd_ptr_q];

  // NOTE: the FIFO storage has no reset; pointers and count alone define validity,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every sequential assignment is non-blocking so all flops update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tmo_q         <= '0;
      iomem_valid_q <= 1'b0;
      iomem_wstrb_q <= '0;
      iomem_addr_q  <= '0;
      iomem_wdata_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tmo_q         <= tmo_d;
      iomem_valid_q <= iomem_valid_d;
      iomem_wstrb_q <= iomem_wstrb_d;
      iomem_addr_q  <= iomem_addr_d;
      iomem_wdata_q <= iomem_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      err_count_q   <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   if (iomem_ready || tmo_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    tmo_d         = tmo_q;
    iomem_valid_d = iomem_valid_q;
    iomem_wstrb_d = iomem_wstrb_q;
    iomem_addr_d  = iomem_addr_q;
    iomem_wdata_d = iomem_wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    err_count_d   = err_count_q;
    unique case (state_q)
      IDLE: if (pop) begin
        iomem_valid_d = 1'b1;
        iomem_addr_d  = head.addr;
        iomem_wdata_d = head.wdata;
        iomem_wstrb_d = head.wstrb;
        tmo_d         = '0;
      end
      ISSUE: begin
        // ready is checked first so a same-cycle ack beats the timeout
        if (iomem_ready) begin
          iomem_valid_d = 1'b0;
          rsp_rdata_d   = (iomem_wstrb_q == 4'h0) ? iomem_rdata : 32'h0;
          rsp_error_d   = 1'b0;
          rsp_valid_d   = 1'b1;
        end else if (tmo_hit) begin
          iomem_valid_d = 1'b0;
          rsp_rdata_d   = 32'h0;
          rsp_error_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign req_ready   = !full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign iomem_valid = iomem_valid_q;
  assign iomem_wstrb = iomem_wstrb_q;
  assign iomem_addr  = iomem_addr_q;
  assign iomem_wdata = iomem_wdata_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign fifo_count  = count_q;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_picosoc_iomem_initiator.sv
// Scoreboard bench for picosoc_iomem_initiator; instance 0 uses an 8-cycle
// timeout, instance 1 a 4-cycle timeout for the ready/timeout collision case.
module tb_picosoc_iomem_initiator;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        error;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_ready [2];
  wire         req_ready [2];
  wire         rsp_valid [2];
  wire  [31:0] rsp_rdata [2];
  wire         rsp_error [2];
  wire         iomem_valid [2];
  wire  [3:0]  iomem_wstrb [2];
  wire  [31:0] iomem_addr  [2];
  wire  [31:0] iomem_wdata [2];
  wire         iomem_ready [2];
  wire  [31:0] iomem_rdata [2];
  wire         busy [2];
  wire  [2:0]  fifo_count [2];
  wire  [7:0]  err_count [2];

  int          resp_delay [2];   // valid cycle on which the responder acks; 0 = never
  int          vcnt [2];
  int          last_len [2];
  logic [31:0] cap_wdata [2];
  logic [3:0]  cap_wstrb [2];

  exp_t sb [$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    picosoc_iomem_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(g == 0 ? 8 : 4)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_wstrb(req_wstrb[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_error(rsp_error[g]),
      .iomem_valid(iomem_valid[g]), .iomem_wstrb(iomem_wstrb[g]),
      .iomem_addr(iomem_addr[g]), .iomem_wdata(iomem_wdata[g]),
      .iomem_ready(iomem_ready[g]), .iomem_rdata(iomem_rdata[g]),
      .busy(busy[g]), .fifo_count(fifo_count[g]), .err_count(err_count[g])
    );
    assign iomem_ready[g] = iomem_valid[g] && (resp_delay[g] != 0) && (vcnt[g] == resp_delay[g] - 1);
    assign iomem_rdata[g] = iomem_addr[g] ^ 32'h0000_00E1;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (iomem_valid[i]) vcnt[i] <= vcnt[i] + 1;
      else begin
        if (vcnt[i] != 0) last_len[i] <= vcnt[i];
        vcnt[i] <= 0;
      end
      if (iomem_ready[i]) begin
        cap_wdata[i] <= iomem_wdata[i];
        cap_wstrb[i] <= iomem_wstrb[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input bit exp_err);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_addr[sel]  = a;
    req_wdata[sel] = wd;
    req_wstrb[sel] = ws;
    req_valid[sel] = 1'b1;
    while (!req_ready[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[sel]) check("push_wait", 32'(req_ready[sel]), 32'd1);
    @(posedge clk);
    #1 req_valid[sel] = 1'b0;
    e.addr  = a;
    e.error = exp_err;
    e.rdata = (ws == 4'h0 && !exp_err) ? (a ^ 32'h0000_00E1) : 32'h0;
    sb.push_back(e);
  endtask

  task automatic get_rsp(input int sel, input string tag);
    int n = 0;
    exp_t e;
    @(negedge clk);
    rsp_ready[sel] = 1'b1;
    while (!rsp_valid[sel] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid[sel]), 32'd1);
    check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_addr"},  iomem_addr[sel], e.addr);
      check({tag, "_rdata"}, rsp_rdata[sel], e.rdata);
      check({tag, "_error"}, 32'(rsp_error[sel]), 32'(e.error));
    end
    @(posedge clk);
    #1 rsp_ready[sel] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
      rsp_ready[i] = 1'b0; resp_delay[i] = 0; vcnt[i] = 0; last_len[i] = 0;
      cap_wdata[i] = '0; cap_wstrb[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_req_ready",   32'(req_ready[0]),   32'd1);
    check("rst_rsp_valid",   32'(rsp_valid[0]),   32'd0);
    check("rst_iomem_valid", 32'(iomem_valid[0]), 32'd0);
    check("rst_busy",        32'(busy[0]),        32'd0);
    check("rst_fifo_count",  32'(fifo_count[0]),  32'd0);
    check("rst_err_count",   32'(err_count[0]),   32'd0);
    check("rst_rsp_rdata",   rsp_rdata[0],        32'd0);
    check("rst_iomem_addr",  iomem_addr[0],       32'd0);

    // read, ack on the 2nd valid cycle
    resp_delay[0] = 2;
    push(0, 32'h0000_0044, 32'h0, 4'h0, 1'b0);
    get_rsp(0, "rd");
    check("rd_valid_len", 32'(last_len[0]), 32'd2);
    check("rd_err_count", 32'(err_count[0]), 32'd0);

    // write, immediate ack
    resp_delay[0] = 1;
    push(0, 32'h0000_0008, 32'h0000_0001, 4'hF, 1'b0);
    get_rsp(0, "wr");
    check("wr_wstrb",     32'(cap_wstrb[0]), 32'h0000_000F);
    check("wr_wdata",     cap_wdata[0],      32'h0000_0001);
    check("wr_valid_len", 32'(last_len[0]),  32'd1);

    // timeout, then saturation of err_count
    resp_delay[0] = 0;
    push(0, 32'h0000_0020, 32'h0, 4'h0, 1'b1);
    get_rsp(0, "tmo");
    check("tmo_valid_len", 32'(last_len[0]),  32'd8);
    check("tmo_err_count", 32'(err_count[0]), 32'd1);
    for (int i = 0; i < 299; i++) begin
      push(0, 32'h0000_1000 + 32'(i), 32'h0, 4'h0, 1'b1);
      get_rsp(0, "sat");
    end
    check("sat_err_count", 32'(err_count[0]), 32'd255);

    // FIFO full and backpressure
    resp_delay[0] = 1;
    for (int i = 0; i < 5; i++) push(0, 32'h0000_0100 * 32'(i + 1), 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    check("full_req_ready",  32'(req_ready[0]),  32'd0);
    check("full_fifo_count", 32'(fifo_count[0]), 32'd4);
    req_addr[0] = 32'h0000_0600;
    req_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("full_blocked_count", 32'(fifo_count[0]), 32'd4);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) get_rsp(0, "drain");
    @(negedge clk);
    check("drain_busy",  32'(busy[0]), 32'd0);
    check("drain_sb",    32'(sb.size()), 32'd0);

    // ready and timeout on the same cycle (instance 1, timeout 4)
    resp_delay[1] = 4;
    push(1, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    get_rsp(1, "coll");
    check("coll_valid_len", 32'(last_len[1]),  32'd4);
    check("coll_err_count", 32'(err_count[1]), 32'd0);

    // reset mid-ISSUE with two entries queued
    resp_delay[0] = 0;
    for (int i = 0; i < 3; i++) push(0, 32'h0000_0700 + 32'(i), 32'h0, 4'h0, 1'b1);
    n = 0;
    while (!iomem_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_iomem_valid", 32'(iomem_valid[0]), 32'd1);
    check("mid_fifo_count",  32'(fifo_count[0]),  32'd2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_iomem_valid", 32'(iomem_valid[0]), 32'd0);
    check("arst_fifo_count",  32'(fifo_count[0]),  32'd0);
    check("arst_rsp_valid",   32'(rsp_valid[0]),   32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (iomem_valid[0] || rsp_valid[0]) seen = 1'b1;
    end
    check("post_rst_activity", 32'(seen),    32'd0);
    check("post_rst_busy",     32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
